// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between CPU writeback and a host port; define RF_CLEAR_EN for the post-reset zeroing sweep.
// Accept at edge N drives rf_* for one cycle; fixed CPU priority, host forced through after HOST_MAX_WAIT denied cycles.
module regfile_wr_arbiter #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NUM_REGS      = 32,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              busy
);

  localparam logic [3:0] WAIT_MAX = 4'(HOST_MAX_WAIT);

  logic              arb_en;
  logic              host_gnt;
  logic              cpu_gnt;
  logic [3:0]        host_wait_q, host_wait_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  // $0 is hardwired and addresses past the last register do not exist.
  function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

`ifdef RF_CLEAR_EN
  typedef enum logic {CLR, ARB} state_t;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;

  assign arb_en = rst_n && (state_q == ARB);
  assign busy   = busy_q;
`else
  assign arb_en = rst_n;
  assign busy   = 1'b0;
`endif

  // Readies are gated by rst_n so they read 0 the moment reset asserts.
  always_comb begin
    host_gnt = arb_en && host_valid && (!cpu_valid || (host_wait_q == WAIT_MAX));
    cpu_gnt  = arb_en && cpu_valid && !host_gnt;
  end

  assign cpu_ready  = cpu_gnt;
  assign host_ready = host_gnt;

  always_comb begin
    host_wait_d = 4'd0;
    if (host_valid && !host_gnt) begin
      host_wait_d = (host_wait_q == WAIT_MAX) ? host_wait_q : host_wait_q + 4'd1;
    end

    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (host_gnt) begin
      rf_we_d   = addr_writable(host_addr);
      rf_addr_d = host_addr;
      rf_data_d = host_data;
    end else if (cpu_gnt) begin
      rf_we_d   = addr_writable(cpu_addr);
      rf_addr_d = cpu_addr;
      rf_data_d = cpu_data;
    end

`ifdef RF_CLEAR_EN
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    if (state_q == CLR) begin
      rf_we_d   = 1'b1;
      rf_addr_d = clr_idx_q;
      rf_data_d = '0;
      clr_idx_d = clr_idx_q + ADDR_W'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d = ARB;
        busy_d  = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_wait_q <= 4'd0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
`ifdef RF_CLEAR_EN
      state_q     <= CLR;
      clr_idx_q   <= ADDR_W'(1);
      busy_q      <= 1'b1;
`endif
    end else begin
      host_wait_q <= host_wait_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
`ifdef RF_CLEAR_EN
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      busy_q      <= busy_d;
`endif
    end
  end

  assign rf_reg_write  = rf_we_q;
  assign rf_rd_addr    = rf_addr_q;
  assign rf_write_data = rf_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a transaction-level model, with a register-file stand-in fed by the DUT.
module tb_regfile_wr_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int HMW = 4;
`ifdef RF_CLEAR_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_valid, host_valid;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_data, host_data;
  logic          cpu_ready, host_ready;
  logic          rf_reg_write;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_write_data;
  logic          busy;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .HOST_MAX_WAIT(HMW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .rf_reg_write(rf_reg_write), .rf_rd_addr(rf_rd_addr), .rf_write_data(rf_write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Requester stimulus: the request each side is currently presenting.
  bit          cv, hv;
  logic [4:0]  ca, ha;
  logic [31:0] cd, hd;

  // Reference model state.
  bit          m_sweep;
  int          m_idx;
  int          m_hw;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_rf [NR];
  logic [31:0] t_rf [NR];
  bit          g_cpu, g_host;
  int          busy_cycles, host_grants;

  task automatic step();
    @(negedge clk);
    cpu_valid  = cv; cpu_addr  = ca; cpu_data  = cd;
    host_valid = hv; host_addr = ha; host_data = hd;
    #1;
    g_host = hv && !m_sweep && (!cv || m_hw == HMW);
    g_cpu  = cv && !m_sweep && !g_host;
    check("cpu_ready", cpu_ready, g_cpu);
    check("host_ready", host_ready, g_host);
    check("busy", busy, m_sweep);
    check("rf_reg_write", rf_reg_write, m_we);
    check("rf_rd_addr", rf_rd_addr, m_addr);
    check("rf_write_data", rf_write_data, m_data);
    if (rf_reg_write && rf_rd_addr != 0) t_rf[rf_rd_addr] = rf_write_data;
    if (m_we) m_rf[m_addr] = m_data;
    if (m_sweep) busy_cycles++;
    if (g_host) host_grants++;
    // Next registered outputs.
    if (m_sweep) begin
      m_we = 1'b1; m_addr = 5'(m_idx); m_data = 0;
      if (m_idx == NR - 1) m_sweep = 1'b0;
      m_idx++;
    end else if (g_host) begin
      m_we = (ha != 0); m_addr = ha; m_data = hd;
    end else if (g_cpu) begin
      m_we = (ca != 0); m_addr = ca; m_data = cd;
    end else begin
      m_we = 1'b0;
    end
    if (hv && !g_host) m_hw = (m_hw >= HMW) ? HMW : m_hw + 1;
    else m_hw = 0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    cpu_valid = 1'b1; host_valid = 1'b1;
    #1;
    check("rst_rf_reg_write", rf_reg_write, 0);
    check("rst_rf_rd_addr", rf_rd_addr, 0);
    check("rst_rf_write_data", rf_write_data, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_busy", busy, SWEEP);
    m_sweep = SWEEP; m_idx = 1; m_hw = 0;
    m_we = 1'b0; m_addr = 0; m_data = 0;
    cv = 0; hv = 0; cpu_valid = 1'b0; host_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_h;
    rst_n = 1'b0;
    cv = 0; hv = 0; ca = 0; ha = 0; cd = 0; hd = 0;
    cpu_valid = 0; host_valid = 0; cpu_addr = 0; host_addr = 0; cpu_data = 0; host_data = 0;
    for (int i = 0; i < NR; i++) begin
      m_rf[i] = (i == 0) ? 32'h0 : 32'hdead_0000 + i;
      t_rf[i] = m_rf[i];
    end
    @(posedge clk);
    do_reset();

    busy_cycles = 0;
    repeat (NR) step();
    check("sweep_busy_cycles", busy_cycles, SWEEP ? NR - 1 : 0);
    if (SWEEP) check("sweep_reg5_zero", t_rf[5], 32'h0);

    // CPU only.
    cv = 1; ca = 1; cd = 32'habcd_1234;
    step();
    check("cpu_only_grant", g_cpu, 1);
    cv = 0;
    repeat (2) step();
    check("cpu_only_reg1", t_rf[1], 32'habcd_1234);

    // Both requesters continuously valid.
    cv = 1; ca = 1; cd = 32'habcd_abcd;
    hv = 1; ha = 2; hd = 32'habcd_5678;
    host_grants = 0; first_h = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (g_host && first_h < 0) first_h = i;
    end
    check("starve_first_host_slot", first_h, 4);
    check("starve_host_grants", host_grants, 2);
    cv = 0; hv = 0;
    repeat (2) step();
    check("starve_reg1", t_rf[1], 32'habcd_abcd);
    check("starve_reg2", t_rf[2], 32'habcd_5678);

    // Write to $0 is accepted but never committed.
    cv = 1; ca = 0; cd = 32'hffff_ffff;
    step();
    check("addr0_grant", g_cpu, 1);
    cv = 0;
    repeat (2) step();
    check("addr0_reg0", t_rf[0], 32'h0);

    // Host only.
    hv = 1; ha = 2; hd = 32'h1357_9bdf;
    step();
    check("host_only_grant", g_host, 1);
    hv = 0;
    repeat (2) step();
    check("host_only_reg2", t_rf[2], 32'h1357_9bdf);

    // Reset during a transfer, then during the sweep.
    cv = 1; ca = 7; cd = 32'h7777_7777;
    step();
    do_reset();
    check("cancelled_reg7", t_rf[7], m_rf[7]);
    repeat (10) step();
    do_reset();
    busy_cycles = 0;
    repeat (NR) step();
    check("resweep_busy_cycles", busy_cycles, SWEEP ? NR - 1 : 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!cv || g_cpu) begin
        cv = ($urandom_range(0, 2) != 0); ca = 5'($urandom_range(0, 31)); cd = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        cv = 0;
      end
      if (!hv || g_host) begin
        hv = ($urandom_range(0, 1) != 0); ha = 5'($urandom_range(0, 31)); hd = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        hv = 0;
      end
    end
    cv = 0; hv = 0;
    repeat (2) step();
    for (int i = 0; i < NR; i++) check($sformatf("final_reg%0d", i), t_rf[i], m_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
